// File: rtl/reloj_hora_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reloj_hora_pkg
// Description : Shared constants, alarm FSM encoding and BCD helper for the
//               time-of-day / alarm core.
//               Contents: SEG_MAX/MIN_MAX/HORA_MAX BCD limits, estado_t,
//               bcd_inc() two-digit BCD increment with wrap at a limit.
// Revision    : 1.0  initial release
// ============================================================================
package reloj_hora_pkg;

  localparam logic [7:0] SEG_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HORA_MAX = 8'h23;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    SONANDO = 1'b1
  } estado_t;

  // Two-digit BCD increment; returns 00 once the limit is reached so a
  // value with a nibble above 9 can never be produced from a valid input.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val,
                                         input logic [7:0] max);
    logic [7:0] res;
    if (val == max) begin
      res = 8'h00;
    end else if (val[3:0] == 4'd9) begin
      res = {val[7:4] + 4'd1, 4'd0};
    end else begin
      res = {val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

endpackage : reloj_hora_pkg
`default_nettype wire

// File: rtl/reloj_hora_if.sv
`default_nettype none
// ============================================================================
// Module      : reloj_hora_if
// Description : Control and display bus of the time-of-day / alarm core.
//               Inputs to the core : tick_in, set_hora, set_alarma, inc_min,
//                                    inc_hora, alarma_en, apagar
//               Outputs of the core: hh, mm, ss, al_hh, al_mm (BCD), alarma
//               master = stimulus/controller side, slave = core side.
// Revision    : 1.0  initial release
// ============================================================================
interface reloj_hora_if;

  logic       tick_in;
  logic       set_hora;
  logic       set_alarma;
  logic       inc_min;
  logic       inc_hora;
  logic       alarma_en;
  logic       apagar;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic [7:0] al_hh;
  logic [7:0] al_mm;
  logic       alarma;

  modport master (
    output tick_in, set_hora, set_alarma, inc_min, inc_hora, alarma_en, apagar,
    input  hh, mm, ss, al_hh, al_mm, alarma
  );

  modport slave (
    input  tick_in, set_hora, set_alarma, inc_min, inc_hora, alarma_en, apagar,
    output hh, mm, ss, al_hh, al_mm, alarma
  );

endinterface : reloj_hora_if
`default_nettype wire

// File: rtl/reloj_hora_contador_bcd.sv
`default_nettype none
// ============================================================================
// Module      : reloj_hora_contador_bcd
// Description : Two-digit BCD counter 00..MAX with synchronous clear.
//               reloje : clock          rstn  : sync reset, active-low
//               inc    : +1 request     clr   : load 00 (wins over inc)
//               value  : registered BCD count
//               wrap   : high in the cycle an inc takes value MAX -> 00
// Revision    : 1.0  initial release
// ============================================================================
module reloj_hora_contador_bcd
  import reloj_hora_pkg::*;
#(
  parameter logic [7:0] MAX     = 8'h59,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  wire logic       reloje,
  input  wire logic       rstn,
  input  wire logic       inc,
  input  wire logic       clr,
  output logic      [7:0] value,
  output logic            wrap
);

  logic [7:0] r_value;

  always_ff @(posedge reloje) begin
    if (!rstn) begin
      r_value <= RST_VAL;
    end else if (clr) begin
      r_value <= 8'h00;
    end else if (inc) begin
      r_value <= bcd_inc(r_value, MAX);
    end
  end

  // Combinational so the next digit pair advances on the same edge; the
  // carry ripples through the whole hh:mm:ss chain in one cycle.
  assign wrap  = inc & ~clr & (r_value == MAX);
  assign value = r_value;

endmodule : reloj_hora_contador_bcd
`default_nettype wire

// File: rtl/reloj_hora.sv
`default_nettype none
// ============================================================================
// Module      : reloj_hora
// Description : Time-of-day (hh:mm:ss BCD, 24 h) and alarm core.
//               reloje : system clock      rstn : sync reset, active-low
//               bus    : reloj_hora_if.slave
//                 in : tick_in (1 Hz level), set_hora, set_alarma,
//                      inc_min, inc_hora, alarma_en, apagar
//                 out: hh, mm, ss, al_hh, al_mm, alarma (all registered)
// Revision    : 1.0  initial release
// ============================================================================
module reloj_hora
  import reloj_hora_pkg::*;
#(
  parameter int unsigned ALARM_SECS  = 60,
  parameter logic [7:0]  HORA_AL_RST = 8'h06
) (
  input  wire logic    reloje,
  input  wire logic    rstn,
  reloj_hora_if.slave  bus
);

  localparam logic [7:0] c_alarm_last = 8'(ALARM_SECS - 1);

  // --------------------------------------------------------------------------
  // Second tick detection
  // --------------------------------------------------------------------------
  logic       r_sync1;
  logic       r_sync2;
  logic       r_edge;
  logic [1:0] r_vld;
  logic       w_sec_pulse;

  // r_vld tracks when r_sync2 first carries a real sample of tick_in. Until
  // then the edge flop is held at 1, so a tick_in already high when reset is
  // released is treated as "old" and never produces a pulse.
  always_ff @(posedge reloje) begin
    if (!rstn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_edge  <= 1'b1;
      r_vld   <= 2'b00;
    end else begin
      r_sync1 <= bus.tick_in;
      r_sync2 <= r_sync1;
      r_vld   <= {r_vld[0], 1'b1};
      r_edge  <= r_vld[1] ? r_sync2 : 1'b1;
    end
  end

  assign w_sec_pulse = r_sync2 & ~r_edge;

  // --------------------------------------------------------------------------
  // Time and alarm registers
  // --------------------------------------------------------------------------
  logic       w_run;
  logic       w_al_set;
  logic       w_ss_wrap;
  logic       w_mm_wrap;
  logic       w_hh_wrap;
  logic       w_alm_wrap;
  logic       w_alh_wrap;
  logic       w_mm_inc;
  logic       w_hh_inc;
  logic [7:0] w_ss;
  logic [7:0] w_mm;
  logic [7:0] w_hh;
  logic [7:0] w_al_mm;
  logic [7:0] w_al_hh;

  assign w_run    = w_sec_pulse & ~bus.set_hora;
  assign w_al_set = bus.set_alarma & ~bus.set_hora;

  // In time-set mode the minute wrap must not reach the hours.
  assign w_mm_inc = w_ss_wrap | (bus.set_hora & bus.inc_min);
  assign w_hh_inc = (w_mm_wrap & ~bus.set_hora) | (bus.set_hora & bus.inc_hora);

  reloj_hora_contador_bcd #(.MAX(SEG_MAX), .RST_VAL(8'h00)) u_ss (
    .reloje (reloje),
    .rstn   (rstn),
    .inc    (w_run),
    .clr    (bus.set_hora),
    .value  (w_ss),
    .wrap   (w_ss_wrap)
  );

  reloj_hora_contador_bcd #(.MAX(MIN_MAX), .RST_VAL(8'h00)) u_mm (
    .reloje (reloje),
    .rstn   (rstn),
    .inc    (w_mm_inc),
    .clr    (1'b0),
    .value  (w_mm),
    .wrap   (w_mm_wrap)
  );

  reloj_hora_contador_bcd #(.MAX(HORA_MAX), .RST_VAL(8'h00)) u_hh (
    .reloje (reloje),
    .rstn   (rstn),
    .inc    (w_hh_inc),
    .clr    (1'b0),
    .value  (w_hh),
    .wrap   (w_hh_wrap)
  );

  reloj_hora_contador_bcd #(.MAX(MIN_MAX), .RST_VAL(8'h00)) u_al_mm (
    .reloje (reloje),
    .rstn   (rstn),
    .inc    (w_al_set & bus.inc_min),
    .clr    (1'b0),
    .value  (w_al_mm),
    .wrap   (w_alm_wrap)
  );

  reloj_hora_contador_bcd #(.MAX(HORA_MAX), .RST_VAL(HORA_AL_RST)) u_al_hh (
    .reloje (reloje),
    .rstn   (rstn),
    .inc    (w_al_set & bus.inc_hora),
    .clr    (1'b0),
    .value  (w_al_hh),
    .wrap   (w_alh_wrap)
  );

  // Day rollover and the alarm digit wraps carry nowhere.
  logic w_unused_wraps;
  assign w_unused_wraps = ^{w_hh_wrap, w_alm_wrap, w_alh_wrap};

  // --------------------------------------------------------------------------
  // Alarm FSM
  // --------------------------------------------------------------------------
  logic       r_tick_upd;
  logic       w_match;
  estado_t    r_estado;
  estado_t    w_estado_nx;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nx;

  // Marks that the time registers were just advanced by a real second, so a
  // match created by manual setting never starts the buzzer.
  always_ff @(posedge reloje) begin
    if (!rstn) begin
      r_tick_upd <= 1'b0;
    end else begin
      r_tick_upd <= w_run;
    end
  end

  assign w_match = (w_hh == w_al_hh) && (w_mm == w_al_mm) && (w_ss == 8'h00);

  always_ff @(posedge reloje) begin
    if (!rstn) begin
      r_estado <= IDLE;
      r_cnt    <= 8'd0;
    end else begin
      r_estado <= w_estado_nx;
      r_cnt    <= w_cnt_nx;
    end
  end

  always_comb begin
    w_estado_nx = r_estado;
    w_cnt_nx    = r_cnt;
    case (r_estado)
      IDLE: begin
        w_cnt_nx = 8'd0;
        if (r_tick_upd && w_match && bus.alarma_en && !bus.set_hora) begin
          w_estado_nx = SONANDO;
        end
      end
      SONANDO: begin
        if (bus.apagar || !bus.alarma_en) begin
          w_estado_nx = IDLE;
          w_cnt_nx    = 8'd0;
        end else if (w_sec_pulse) begin
          // Leave on the edge the count would reach ALARM_SECS.
          if (r_cnt == c_alarm_last) begin
            w_estado_nx = IDLE;
            w_cnt_nx    = 8'd0;
          end else begin
            w_cnt_nx = r_cnt + 8'd1;
          end
        end
      end
      default: begin
        w_estado_nx = IDLE;
        w_cnt_nx    = 8'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs (all straight from flops)
  // --------------------------------------------------------------------------
  assign bus.hh     = w_hh;
  assign bus.mm     = w_mm;
  assign bus.ss     = w_ss;
  assign bus.al_hh  = w_al_hh;
  assign bus.al_mm  = w_al_mm;
  assign bus.alarma = (r_estado == SONANDO);

endmodule : reloj_hora
`default_nettype wire

// File: tb/tb_reloj_hora.sv
`default_nettype none
// ============================================================================
// Module      : tb_reloj_hora
// Description : Self-checking bench for reloj_hora (ALARM_SECS = 3).
// Revision    : 1.0  initial release
// ============================================================================
module tb_reloj_hora;

  localparam int ASECS = 3;

  logic reloje = 1'b0;
  logic rstn   = 1'b0;
  reloj_hora_if bus ();

  reloj_hora #(.ALARM_SECS(ASECS), .HORA_AL_RST(8'h06)) dut (
    .reloje (reloje),
    .rstn   (rstn),
    .bus    (bus)
  );

  always #5 reloje = ~reloje;

  int n_chk  = 0;
  int n_pass = 0;
  bit bcd_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: time as seconds-of-day, alarm as plain integers
  // --------------------------------------------------------------------------
  typedef struct {
    int       secs;
    int       alh;
    int       alm;
    bit       snd;
    int       cnt;
    bit       just;
    bit [2:0] hist;   // [0] newest tick_in sample
  } m_t;

  m_t m;

  function automatic m_t mdl_next(m_t c, logic rn, logic tk, logic sh, logic sa,
                                  logic im, logic ih, logic en, logic ap);
    m_t n = c;
    bit pulse;
    int h, mi, s;
    if (!rn) begin
      n.secs = 0; n.alh = 6; n.alm = 0; n.snd = 0; n.cnt = 0; n.just = 0;
      n.hist = 3'b111;
      return n;
    end
    // A second counts on the 3rd edge after tick_in is first sampled high.
    pulse  = c.hist[1] & ~c.hist[2];
    n.hist = {c.hist[1:0], tk};
    h  = c.secs / 3600;
    mi = (c.secs / 60) % 60;
    s  = c.secs % 60;
    if (c.snd) begin
      if (ap || !en) begin
        n.snd = 0; n.cnt = 0;
      end else if (pulse) begin
        n.cnt = c.cnt + 1;
        if (n.cnt == ASECS) begin n.snd = 0; n.cnt = 0; end
      end
    end else if (c.just && h == c.alh && mi == c.alm && s == 0 && en && !sh) begin
      n.snd = 1;
    end
    n.just = pulse && !sh;
    if (sh) n.secs = ((h + int'(ih)) % 24) * 3600 + ((mi + int'(im)) % 60) * 60;
    else if (pulse) n.secs = (c.secs + 1) % 86400;
    if (!sh && sa) begin
      n.alm = (c.alm + int'(im)) % 60;
      n.alh = (c.alh + int'(ih)) % 24;
    end
    return n;
  endfunction

  function automatic logic [7:0] to_bcd(int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  always @(posedge reloje)
    m <= mdl_next(m, rstn, bus.tick_in, bus.set_hora, bus.set_alarma,
                  bus.inc_min, bus.inc_hora, bus.alarma_en, bus.apagar);

  // Digits must stay strict BCD at all times.
  always @(negedge reloje) begin
    if (bcd_on) begin
      chk("bcd_digits",
          32'({bus.ss[7:4] <= 4'd5, bus.ss[3:0] <= 4'd9, bus.mm[7:4] <= 4'd5,
               bus.mm[3:0] <= 4'd9, bus.hh <= 8'h23, bus.hh[3:0] <= 4'd9}),
          32'h3f);
    end
  end

  // --------------------------------------------------------------------------
  // Helpers (inputs change right after the falling edge)
  // --------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge reloje);
  endtask

  task automatic reset_dut();
    rstn = 1'b0; cyc(2); rstn = 1'b1; cyc(4);
  endtask

  task automatic press_min(input int n);
    repeat (n) begin bus.inc_min = 1'b1; cyc(1); bus.inc_min = 1'b0; end
  endtask

  task automatic press_hora(input int n);
    repeat (n) begin bus.inc_hora = 1'b1; cyc(1); bus.inc_hora = 1'b0; end
  endtask

  task automatic do_tick();
    bus.tick_in = 1'b1; cyc(3); bus.tick_in = 1'b0; cyc(3);
  endtask

  task automatic chk_time(input string name, input logic [7:0] h, input logic [7:0] mi,
                          input logic [7:0] s);
    chk({name, "_hh"}, 32'(bus.hh), 32'(h));
    chk({name, "_mm"}, 32'(bus.mm), 32'(mi));
    chk({name, "_ss"}, 32'(bus.ss), 32'(s));
  endtask

  task automatic chk_reset_vals(input string name);
    chk_time(name, 8'h00, 8'h00, 8'h00);
    chk({name, "_al_hh"}, 32'(bus.al_hh), 32'h06);
    chk({name, "_al_mm"}, 32'(bus.al_mm), 32'h00);
    chk({name, "_alarma"}, 32'(bus.alarma), 32'h0);
  endtask

  // Reset, set 05:59, run to 05:59:59 and one more tick: alarm sounds.
  task automatic arm_alarm();
    reset_dut();
    bus.alarma_en = 1'b1;
    bus.set_hora  = 1'b1;
    press_hora(5); press_min(59);
    bus.set_hora  = 1'b0;
    repeat (60) do_tick();
    chk("arm_alarma", 32'(bus.alarma), 32'h1);
  endtask

  // --------------------------------------------------------------------------
  // Table of set-mode vectors, applied in sequence from reset
  // --------------------------------------------------------------------------
  typedef struct {
    logic       sh, sa, im, ih;
    logic [7:0] hh, mm, alh, alm;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1, 0, 1, 0, 8'h00, 8'h01, 8'h06, 8'h00};
    tbl[1] = '{1, 0, 0, 1, 8'h01, 8'h01, 8'h06, 8'h00};
    tbl[2] = '{1, 0, 1, 1, 8'h02, 8'h02, 8'h06, 8'h00};
    tbl[3] = '{0, 1, 1, 0, 8'h02, 8'h02, 8'h06, 8'h01};
    tbl[4] = '{0, 1, 0, 1, 8'h02, 8'h02, 8'h07, 8'h01};
    tbl[5] = '{1, 1, 0, 1, 8'h03, 8'h02, 8'h07, 8'h01};
    tbl[6] = '{0, 0, 1, 1, 8'h03, 8'h02, 8'h07, 8'h01};
    tbl[7] = '{0, 1, 1, 1, 8'h03, 8'h02, 8'h08, 8'h02};

    bus.tick_in = 0; bus.set_hora = 0; bus.set_alarma = 0; bus.inc_min = 0;
    bus.inc_hora = 0; bus.alarma_en = 0; bus.apagar = 0;

    cyc(3);
    chk_reset_vals("reset");
    bcd_on = 1'b1;
    rstn = 1'b1;
    cyc(4);

    for (int i = 0; i < 8; i++) begin
      bus.set_hora = tbl[i].sh; bus.set_alarma = tbl[i].sa;
      bus.inc_min  = tbl[i].im; bus.inc_hora   = tbl[i].ih;
      cyc(1);
      bus.set_hora = 0; bus.set_alarma = 0; bus.inc_min = 0; bus.inc_hora = 0;
      chk($sformatf("vec%0d_hh", i), 32'(bus.hh), 32'(tbl[i].hh));
      chk($sformatf("vec%0d_mm", i), 32'(bus.mm), 32'(tbl[i].mm));
      chk($sformatf("vec%0d_al_hh", i), 32'(bus.al_hh), 32'(tbl[i].alh));
      chk($sformatf("vec%0d_al_mm", i), 32'(bus.al_mm), 32'(tbl[i].alm));
      chk($sformatf("vec%0d_ss", i), 32'(bus.ss), 32'h00);
    end

    // Full rollover 23:59:59 -> 00:00:00
    reset_dut();
    bus.set_hora = 1; press_hora(23); press_min(59); bus.set_hora = 0;
    repeat (59) do_tick();
    chk_time("pre_roll", 8'h23, 8'h59, 8'h59);
    do_tick();
    chk_time("roll", 8'h00, 8'h00, 8'h00);

    // Tick latency: rise between edges, update on the 3rd edge only
    reset_dut();
    bus.tick_in = 1; cyc(2);
    chk("lat_edge2_ss", 32'(bus.ss), 32'h00);
    cyc(1);
    chk("lat_edge3_ss", 32'(bus.ss), 32'h01);
    cyc(1000);
    chk("held_high_ss", 32'(bus.ss), 32'h01);
    bus.tick_in = 0; cyc(4);

    // tick_in already high at reset release: no second counted
    bus.tick_in = 1; rstn = 0; cyc(2); rstn = 1; cyc(10);
    chk("high_at_release_ss", 32'(bus.ss), 32'h00);
    bus.tick_in = 0; cyc(4);

    // Set mode
    reset_dut();
    bus.set_hora = 1; press_min(59);
    chk("set_mm59", 32'(bus.mm), 32'h59);
    press_min(1);
    chk("set_mm_wrap_mm", 32'(bus.mm), 32'h00);
    chk("set_mm_wrap_hh", 32'(bus.hh), 32'h00);
    press_hora(23); press_min(59);
    bus.inc_min = 1; bus.inc_hora = 1; cyc(1); bus.inc_min = 0; bus.inc_hora = 0;
    chk_time("set_both", 8'h00, 8'h00, 8'h00);
    repeat (3) do_tick();
    chk("set_tick_ss", 32'(bus.ss), 32'h00);
    bus.set_hora = 0;
    repeat (5) do_tick();
    chk("run5_ss", 32'(bus.ss), 32'h05);
    bus.set_hora = 1; cyc(1);
    chk("set_force_ss", 32'(bus.ss), 32'h00);
    bus.set_hora = 0; cyc(2);

    // Alarm timeout
    reset_dut();
    bus.alarma_en = 1;
    bus.set_hora = 1; press_hora(5); press_min(59); bus.set_hora = 0;
    repeat (59) do_tick();
    chk_time("al_pre", 8'h05, 8'h59, 8'h59);
    bus.tick_in = 1; cyc(3);
    chk_time("al_match", 8'h06, 8'h00, 8'h00);
    chk("al_match_alarma", 32'(bus.alarma), 32'h0);
    cyc(1);
    chk("al_on", 32'(bus.alarma), 32'h1);
    bus.tick_in = 0; cyc(3);
    do_tick(); do_tick();
    chk("al_after2", 32'(bus.alarma), 32'h1);
    bus.tick_in = 1; cyc(3);
    chk("al_timeout", 32'(bus.alarma), 32'h0);
    bus.tick_in = 0; cyc(3);

    // apagar silences; apagar in IDLE harmless
    arm_alarm();
    bus.apagar = 1; cyc(1); bus.apagar = 0;
    chk("apagar", 32'(bus.alarma), 32'h0);
    bus.apagar = 1; cyc(1); bus.apagar = 0;
    chk("apagar_idle_ss", 32'(bus.ss), 32'h00);

    // alarma_en drop silences
    arm_alarm();
    bus.alarma_en = 0; cyc(1);
    chk("en_drop", 32'(bus.alarma), 32'h0);

    // Reset mid-alarm
    arm_alarm();
    rstn = 0; cyc(1);
    chk_reset_vals("rst_mid_alarm");
    rstn = 1; cyc(4);

    // Priority and manual match
    reset_dut();
    bus.alarma_en = 1; bus.set_hora = 1; bus.set_alarma = 1;
    press_hora(1);
    chk("prio_hh", 32'(bus.hh), 32'h01);
    chk("prio_al_hh", 32'(bus.al_hh), 32'h06);
    press_hora(5);
    bus.set_alarma = 0; bus.set_hora = 0; cyc(5);
    chk_time("manual_match", 8'h06, 8'h00, 8'h00);
    chk("manual_no_alarm", 32'(bus.alarma), 32'h0);

    // Randomized run against the reference model
    reset_dut();
    bus.set_hora = 1; press_hora(5); press_min(58); bus.set_hora = 0;
    for (int i = 0; i < 4000; i++) begin
      chk("rnd_hh", 32'(bus.hh), 32'(to_bcd(m.secs / 3600)));
      chk("rnd_mm", 32'(bus.mm), 32'(to_bcd((m.secs / 60) % 60)));
      chk("rnd_ss", 32'(bus.ss), 32'(to_bcd(m.secs % 60)));
      chk("rnd_al_hh", 32'(bus.al_hh), 32'(to_bcd(m.alh)));
      chk("rnd_al_mm", 32'(bus.al_mm), 32'(to_bcd(m.alm)));
      chk("rnd_alarma", 32'(bus.alarma), 32'(m.snd));
      if ($urandom_range(0, 2) == 0) bus.tick_in = ~bus.tick_in;
      if ($urandom_range(0, 299) == 0) bus.set_hora = ~bus.set_hora;
      if ($urandom_range(0, 149) == 0) bus.set_alarma = ~bus.set_alarma;
      if ($urandom_range(0, 299) == 0) bus.alarma_en = ~bus.alarma_en;
      bus.inc_min  = ($urandom_range(0, 7) == 0);
      bus.inc_hora = ($urandom_range(0, 7) == 0);
      bus.apagar   = ($urandom_range(0, 31) == 0);
      rstn         = ($urandom_range(0, 1499) != 0);
      cyc(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_reloj_hora
`default_nettype wire

// File: doc/reloj_hora.md
Name: reloj_hora

Overview:
- Time-of-day and alarm core of the alarm clock. Consumes the slow square wave from the frequency divider; one rising edge of that wave is one second.
- Keeps hh:mm:ss in BCD, 24 h format, plus a settable alarm hh:mm. Drives the buzzer enable.
- Feeds the display multiplexer downstream.

Parameters:
- ALARM_SECS, 60, seconds the alarm output stays asserted unless silenced (1..255).
- HORA_AL_RST, 8'h06, BCD alarm hour loaded at reset.

Ports:
- reloje  in  1  system clock; all logic on rising edge.
- rstn  in  1  synchronous reset, active-low.
- tick_in  in  1  divided clock (level, asynchronous to reloje sampling); rising edge = +1 s.
- set_hora  in  1  level; time-set mode while high.
- set_alarma  in  1  level; alarm-set mode while high.
- inc_min  in  1  one-cycle pulse, pre-debounced.
- inc_hora  in  1  one-cycle pulse, pre-debounced.
- alarma_en  in  1  level; alarm armed while high.
- apagar  in  1  one-cycle pulse; silences a sounding alarm.
- hh  out  8  hours BCD, 00..23.
- mm  out  8  minutes BCD, 00..59.
- ss  out  8  seconds BCD, 00..59.
- al_hh  out  8  alarm hours BCD.
- al_mm  out  8  alarm minutes BCD.
- alarma  out  1  buzzer enable.

Behaviour:
- Reset (rstn=0 at a reloje edge):
  - hh=mm=ss=00.
  - al_hh=HORA_AL_RST, al_mm=00.
  - alarma=0, FSM=IDLE, seconds-in-alarm counter=0.
  - Synchronizer flops cleared.
  - Applies mid-operation, including mid-alarm.
- Tick detect:
  - tick_in passes through a 2-flop synchronizer, then an edge flop. sec_pulse = sync2 & ~edge.
  - The time registers update at the 3rd rising reloje edge after tick_in rises.
  - tick_in high at reset release produces no pulse.
- Normal run (set_hora=0):
  - On sec_pulse, ss increments. 59→00 carries to mm, mm 59→00 carries to hh, hh 23→00.
  - All digits are strict BCD; no value with a nibble >9 is ever produced.
- Time set (set_hora=1):
  - sec_pulse is ignored and ss is held at 00 (forced on the cycle set_hora is first seen high).
  - inc_min: mm+1 mod 60, no carry into hh.
  - inc_hora: hh+1 mod 24.
  - Both pulses in the same cycle: both apply.
- Alarm set (set_alarma=1, set_hora=0):
  - inc_min / inc_hora modify al_mm / al_hh with the same modulo rules. The clock keeps running.
- set_hora and set_alarma both high: set_hora has priority; alarm registers are untouched.
- Neither set line high: inc pulses are ignored.
- Alarm FSM states: IDLE, SONANDO.
  - IDLE→SONANDO on the edge after the time registers become al_hh:al_mm:00 via a normal tick, with alarma_en=1 and set_hora=0. Entering the match by manual setting does not trigger.
  - In SONANDO, alarma=1. The counter increments on each sec_pulse.
  - SONANDO→IDLE on whichever comes first:
    - counter reaches ALARM_SECS (alarma drops on the same edge the counter hits it);
    - apagar=1;
    - alarma_en=0.
  - Counter clears on exit.
  - apagar in IDLE has no effect.
  - A match while already SONANDO does not restart the counter.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - BCD limit constants: SEG_MAX=8'h59, MIN_MAX=8'h59, HORA_MAX=8'h23.
  - FSM state encoding: IDLE=1'b0, SONANDO=1'b1.
- One natural sub-module, contador_bcd:
  - 2-digit BCD counter with parameter MAX.
  - Inputs inc and clr.
  - Outputs value and a one-cycle wrap flag.
  - Instantiated for ss/mm/hh and for al_mm/al_hh.

Test Plan:
- Rollover: preload 23:59:59 via set mode, then 1 tick → 00:00:00. Assert ss/mm/hh never hold an invalid BCD nibble.
- Tick latency: tick_in rises between reloje edges → ss changes exactly at the 3rd edge. Hold tick_in high 1000 cycles → exactly one increment.
- Set mode:
  - set_hora=1, mm=59, pulse inc_min → mm=00 with hh unchanged.
  - Same-cycle inc_min+inc_hora from 23:59 → 00:00.
  - Ticks during set_hora → ss stays 00.
- Alarm timeout: ALARM_SECS=3, alarm 06:00, time 05:59:59, alarma_en=1, 1 tick → alarma=1 one edge after 06:00:00. After 3 more ticks → alarma=0.
- Silence paths:
  - Mid-alarm apagar → alarma=0 next edge.
  - Repeat the alarm with alarma_en dropped → alarma=0.
  - Repeat with rstn=0 → all outputs reach reset values, al_hh=06.
- Priority: set_hora=1 and set_alarma=1, pulse inc_hora → hh+1, al_hh unchanged. Manually set the time to 06:00:00 → no alarm.
